flash_read_ctrl: RTL
====================

# flash_read_ctrl

SPI-flash read controller: on a `key_flag` pulse it issues a READ command plus a 24-bit address to the SPI flash and clocks in `DATA_NUM` bytes on `miso`. Each received byte is presented as a byte/strobe pair for a downstream sink such as a UART transmitter or FIFO. It sits downstream of the page-program controller and reads back the page it wrote (default address 0x0000C8). It uses the same SPI timing: SCK = sys_clk/4, mode 0, 32 sys_clk per byte slot.

## Interface
Parameters:
- `DATA_NUM`, 270: number of data bytes read per transaction; legal range 1..65000.
- `S_ADDR`, 8'h00: sector address byte (address bits 23:16).
- `P_ADDR`, 8'h00: page address byte (address bits 15:8).
- `B_ADDR`, 8'hC8: byte address (address bits 7:0).

Ports:
- `sys_clk`, in, 1: system clock; all logic on rising edge.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `key_flag`, in, 1: one-cycle start pulse, already debounced.
- `miso`, in, 1: flash serial data out.
- `cs_n`, out, 1: flash chip select, active low.
- `sck`, out, 1: SPI clock.
- `mosi`, out, 1: flash serial data in.
- `po_data`, out, 8: last received byte, MSB first on the wire.
- `po_flag`, out, 1: one-cycle strobe; `po_data` is valid in the same cycle.
- `busy`, out, 1: high from the cycle after the accepted `key_flag` until `cs_n` returns high.

## Operation
- State machine is one-hot with three states: IDLE, SEND, RECV.
- IDLE -> SEND on `key_flag`. SEND -> RECV at the end of the last command/address slot. RECV -> IDLE at the end of the final hold slot.
- Counters:
  - `cnt_clk` is 5 bits and runs only when not IDLE; it wraps 31 -> 0.
  - `cnt_byte` is 16 bits and increments at `cnt_clk == 31`; it clears to 0 on return to IDLE.
- Slot map (NCMD = 4):
  - Slot 0: setup; `cs_n` low, no SCK.
  - Slots 1..4: command 8'h03, then `S_ADDR`, `P_ADDR`, `B_ADDR`.
  - Slots NCMD+1 .. NCMD+DATA_NUM: data.
  - Slot NCMD+DATA_NUM+1: hold; no SCK.
- Bit timing inside an active slot, for bit k = 0..7 (bits transmitted MSB first):
  - `mosi` changes at `cnt_clk == 4k`.
  - `sck` is low for `cnt_clk` 4k and 4k+1, and high for 4k+2 and 4k+3.
- `mosi` is driven 0 in the setup slot, the data slots and the hold slot.
- Receive: `miso` is shifted into an 8-bit register on the rising sys_clk edge that ends cycle `cnt_clk == 4k+2`.
- Output: at the end of `cnt_clk == 31` in each data slot, the shift register is copied to `po_data` and `po_flag` is pulsed for exactly one cycle.
- `key_flag` is ignored while `busy` is high.
- Reset mid-transaction aborts immediately. All outputs return to their reset values, the flash sees `cs_n` rise, and no partial byte is flagged.
- There is no address wrap handling; the flash auto-increments its internal address.

## Timing
- Reset values: `cs_n`=1, `sck`=0, `mosi`=0, `po_data`=8'h00, `po_flag`=0, `busy`=0, state = IDLE.
- `cs_n` falls in the cycle after `key_flag`. It rises after (NCMD+DATA_NUM+2)×32 clocks in the low state: 8832 cycles for the default configuration.
- First `po_flag` arrives (NCMD+2)×32 = 192 cycles after `cs_n` falls.
- Successive `po_flag` pulses are exactly 32 cycles apart.
- The last `po_flag` precedes the rise of `cs_n` by 32 cycles.
- Back-to-back operation: a `key_flag` in the first IDLE cycle after `busy` falls is accepted.

## Configuration
- Macro: `FLASH_READ_FAST_EN`.
- Defined:
  - The command byte is 8'h0B (FAST_READ).
  - NCMD = 5: one dummy slot with `mosi`=0 and SCK running follows `B_ADDR`. `miso` is not captured and `po_flag` does not pulse in the dummy slot.
  - All later slots shift by one slot.
- Undefined: the command byte is 8'h03 and NCMD = 4.

## Test plan
- **Default read:** a flash model preloaded with 0x00..0xFF, then 0xAA ×14, at 0x0000C8; pulse `key_flag`.
  - `mosi` must carry 0x03, 0x00, 0x00, 0xC8.
  - 270 `po_flag` pulses, with `po_data` = 0x00..0xFF then 0xAA.
  - `cs_n` low for 8832 cycles.
- **Busy ignore:** pulse `key_flag` again 1000 cycles into a transaction -> no restart; total `po_flag` count stays 270.
- **Mid-transaction reset:** assert `sys_rst_n`=0 at data slot 10, bit 3.
  - `cs_n`=1, `sck`=0 and `po_flag`=0 immediately.
  - A new `key_flag` after release gives a clean transaction whose first byte is 0x00.
- **Single-byte read:** DATA_NUM=1, model byte 0x5A -> exactly one `po_flag`, with `po_data`=0x5A, at cycle 192 after `cs_n` falls; `cs_n` low for 224 cycles.
- **Fast read:** with `FLASH_READ_FAST_EN` defined -> opcode 0x0B, dummy slot, first `po_flag` at cycle 224, `cs_n` low for 8864 cycles, and data identical to the default read.

Source files
------------

// File: rtl/flash_read_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_read_ctrl - SPI-flash READ (0x03) controller, FLASH_READ_FAST_EN selects
// FAST_READ (0x0B) with one dummy slot.                          Rev 1.0
// ---------------------------------------------------------------------------
module flash_read_ctrl #(
  parameter int         DATA_NUM = 270,
  parameter logic [7:0] S_ADDR   = 8'h00,
  parameter logic [7:0] P_ADDR   = 8'h00,
  parameter logic [7:0] B_ADDR   = 8'hC8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_flag,
  input  logic       miso,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       busy
);

`ifdef FLASH_READ_FAST_EN
  localparam int         NCMD = 5;
  localparam logic [7:0] CMD  = 8'h0B;
`else
  localparam int         NCMD = 4;
  localparam logic [7:0] CMD  = 8'h03;
`endif

  localparam logic [15:0] LAST_CMD  = 16'(NCMD);
  localparam logic [15:0] LAST_DATA = 16'(NCMD + DATA_NUM);
  localparam logic [15:0] HOLD_SLOT = 16'(NCMD + DATA_NUM + 1);

  localparam logic [2:0] IDLE = 3'b001;
  localparam logic [2:0] SEND = 3'b010;
  localparam logic [2:0] RECV = 3'b100;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_clk_q, cnt_clk_d;
  logic [15:0] cnt_byte_q, cnt_byte_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  po_data_q, po_data_d;
  logic        po_flag_q, po_flag_d;
  logic        slot_end;
  logic        data_slot;
  logic [7:0]  tx_byte;

  assign slot_end = (cnt_clk_q == 5'd31);
  // RECV is entered at the first data slot, so only the hold slot must be excluded
  assign data_slot = (state_q == RECV) && (cnt_byte_q <= LAST_DATA);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_clk_q  <= 5'd0;
      cnt_byte_q <= 16'd0;
      shift_q    <= 8'h00;
      po_data_q  <= 8'h00;
      po_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_clk_q  <= cnt_clk_d;
      cnt_byte_q <= cnt_byte_d;
      shift_q    <= shift_d;
      po_data_q  <= po_data_d;
      po_flag_q  <= po_flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_flag) state_d = SEND;
      SEND:    if (slot_end && cnt_byte_q == LAST_CMD) state_d = RECV;
      RECV:    if (slot_end && cnt_byte_q == HOLD_SLOT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clk_d  = (state_q == IDLE) ? 5'd0 : cnt_clk_q + 5'd1;
    cnt_byte_d = cnt_byte_q;
    if (state_d == IDLE)
      cnt_byte_d = 16'd0;
    else if (state_q != IDLE && slot_end)
      cnt_byte_d = cnt_byte_q + 16'd1;

    shift_d = shift_q;
    if (data_slot && cnt_clk_q[1:0] == 2'd2)
      shift_d = {shift_q[6:0], miso};

    po_flag_d = data_slot && slot_end;
    po_data_d = po_flag_d ? shift_q : po_data_q;
  end

  always_comb begin
    cs_n    = 1'b1;
    busy    = 1'b0;
    sck     = 1'b0;
    tx_byte = 8'h00;
    if (state_q != IDLE) begin
      cs_n = 1'b0;
      busy = 1'b1;
      if (cnt_byte_q != 16'd0 && cnt_byte_q != HOLD_SLOT)
        sck = cnt_clk_q[1];
      case (cnt_byte_q)
        16'd1:   tx_byte = CMD;
        16'd2:   tx_byte = S_ADDR;
        16'd3:   tx_byte = P_ADDR;
        16'd4:   tx_byte = B_ADDR;
        default: tx_byte = 8'h00;
      endcase
    end
    // bit k of the slot goes out MSB first, so index 7-k == ~k
    mosi    = tx_byte[~cnt_clk_q[4:2]];
    po_data = po_data_q;
    po_flag = po_flag_q;
  end

endmodule
`default_nettype wire
